// File: rtl/rv_decode_stage.sv
// RISC-V decode stage: combinational decode of one instruction per cycle into an op class
// and operand flags, registered through an output register backed by a one-entry skid register.
module rv_decode_stage #(
    parameter int unsigned PC_BITWIDTH    = 32,
    parameter bit          ENABLE_M       = 1'b1,
    parameter bit          ENABLE_ZICSR   = 1'b1,
    parameter bit          ENABLE_FENCE_I = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [31:0]            in_IR,
    input  logic [PC_BITWIDTH-1:0] in_PC,
    input  logic                   in_is_compressed,
    output logic [4:0]             rs1,
    output logic [4:0]             rs2,
    output logic [11:0]            csr,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_IR,
    output logic [PC_BITWIDTH-1:0] out_PC,
    output logic [4:0]             out_rd,
    output logic [3:0]             out_op,
    output logic                   out_use_rs1,
    output logic                   out_use_rs2,
    output logic                   out_use_imm,
    output logic                   out_save_to_rd,
    output logic                   out_csr_write,
    output logic                   out_illegal,
    output logic                   out_is_compressed
);

    localparam int unsigned OP_W = 4;

    localparam logic [OP_W-1:0] OP_ALU     = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MULDIV  = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LUI     = OP_W'(2);
    localparam logic [OP_W-1:0] OP_AUIPC   = OP_W'(3);
    localparam logic [OP_W-1:0] OP_JAL     = OP_W'(4);
    localparam logic [OP_W-1:0] OP_JALR    = OP_W'(5);
    localparam logic [OP_W-1:0] OP_BRANCH  = OP_W'(6);
    localparam logic [OP_W-1:0] OP_LOAD    = OP_W'(7);
    localparam logic [OP_W-1:0] OP_STORE   = OP_W'(8);
    localparam logic [OP_W-1:0] OP_CSR     = OP_W'(9);
    localparam logic [OP_W-1:0] OP_MRET    = OP_W'(10);
    localparam logic [OP_W-1:0] OP_WFI     = OP_W'(11);
    localparam logic [OP_W-1:0] OP_FENCE_I = OP_W'(12);
    localparam logic [OP_W-1:0] OP_NOP     = OP_W'(13);
    localparam logic [OP_W-1:0] OP_ILL     = OP_W'(15);

    typedef struct packed {
        logic [31:0]            ir;
        logic [PC_BITWIDTH-1:0] pc;
        logic [4:0]             rd;
        logic [OP_W-1:0]        op;
        logic                   use_rs1;
        logic                   use_rs2;
        logic                   use_imm;
        logic                   save_to_rd;
        logic                   csr_write;
        logic                   illegal;
        logic                   is_compressed;
    } dec_t;

    dec_t dec;
    dec_t o_q, o_d, s_q, s_d;
    logic o_valid, o_valid_d, s_valid, s_valid_d;
    logic accept, drain;

    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [11:0] funct12;

    assign funct3  = in_IR[14:12];
    assign funct7  = in_IR[31:25];
    assign funct12 = in_IR[31:20];

    assign rs1 = in_IR[19:15];
    assign rs2 = in_IR[24:20];
    assign csr = in_IR[31:20];

    // Instruction decode
    always_comb begin
        dec               = '0;
        dec.ir            = in_IR;
        dec.pc            = in_PC;
        dec.rd            = in_IR[11:7];
        dec.is_compressed = in_is_compressed;
        dec.op            = OP_ILL;
        if (in_IR != '0 && in_IR != '1 && in_IR[1:0] == 2'b11) begin
            case (in_IR[6:2])
                5'b01100: begin
                    if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
                        dec.op = OP_ALU;
                        {dec.use_rs1, dec.use_rs2, dec.save_to_rd} = 3'b111;
                    end else if (funct7 == 7'b0000001 && ENABLE_M) begin
                        dec.op = OP_MULDIV;
                        {dec.use_rs1, dec.use_rs2, dec.save_to_rd} = 3'b111;
                    end
                end
                5'b00100: begin
                    dec.op = OP_ALU;
                    {dec.use_rs1, dec.use_imm, dec.save_to_rd} = 3'b111;
                end
                5'b01101: begin dec.op = OP_LUI;   dec.save_to_rd = 1'b1; end
                5'b00101: begin dec.op = OP_AUIPC; dec.save_to_rd = 1'b1; end
                5'b11011: begin dec.op = OP_JAL;   dec.save_to_rd = 1'b1; end
                5'b11001: begin
                    dec.op = OP_JALR;
                    {dec.use_rs1, dec.save_to_rd} = 2'b11;
                end
                5'b11000: begin
                    dec.op = OP_BRANCH;
                    {dec.use_rs1, dec.use_rs2} = 2'b11;
                end
                5'b00000: begin
                    dec.op = OP_LOAD;
                    {dec.use_rs1, dec.save_to_rd} = 2'b11;
                end
                5'b01000: begin
                    dec.op = OP_STORE;
                    {dec.use_rs1, dec.use_rs2} = 2'b11;
                end
                5'b00011: begin
                    if (funct3 == 3'b000)      dec.op = OP_NOP;
                    else if (funct3 == 3'b001) dec.op = ENABLE_FENCE_I ? OP_FENCE_I : OP_NOP;
                end
                5'b11100: begin
                    if (funct3 == 3'b000) begin
                        if (funct12 == 12'h302)      dec.op = OP_MRET;
                        else if (funct12 == 12'h105) dec.op = OP_WFI;
                    end else if (funct3 != 3'b100 && ENABLE_ZICSR) begin
                        dec.op         = OP_CSR;
                        dec.use_rs1    = 1'b1;
                        dec.save_to_rd = (in_IR[11:7] != 5'd0);
                        dec.csr_write  = (in_IR[19:15] != 5'd0);
                    end
                end
                default: dec.op = OP_ILL;
            endcase
        end
        dec.illegal = (dec.op == OP_ILL);
    end

    assign in_ready = ~s_valid;
    assign accept   = in_valid & ~s_valid;
    assign drain    = o_valid & out_ready;

    // Output/skid register next state; flush wins over everything
    always_comb begin
        o_d       = o_q;
        s_d       = s_q;
        o_valid_d = o_valid;
        s_valid_d = s_valid;
        if (flush) begin
            o_valid_d = 1'b0;
            s_valid_d = 1'b0;
        end else if (!o_valid || drain) begin
            if (s_valid) begin
                o_d       = s_q;
                o_valid_d = 1'b1;
                s_valid_d = accept;
                if (accept) s_d = dec;
            end else if (accept) begin
                o_d       = dec;
                o_valid_d = 1'b1;
            end else begin
                o_valid_d = 1'b0;
            end
        end else if (accept) begin
            s_d       = dec;
            s_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            o_q     <= '0;
            s_q     <= '0;
            o_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            o_q     <= o_d;
            s_q     <= s_d;
            o_valid <= o_valid_d;
            s_valid <= s_valid_d;
        end
    end

    assign out_valid         = o_valid;
    assign out_IR            = o_q.ir;
    assign out_PC            = o_q.pc;
    assign out_rd            = o_q.rd;
    assign out_op            = o_q.op;
    assign out_use_rs1       = o_q.use_rs1;
    assign out_use_rs2       = o_q.use_rs2;
    assign out_use_imm       = o_q.use_imm;
    assign out_save_to_rd    = o_q.save_to_rd;
    assign out_csr_write     = o_q.csr_write;
    assign out_illegal       = o_q.illegal;
    assign out_is_compressed = o_q.is_compressed;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: a full-feature instance plus a reduced instance
// (no M, no Zicsr, no FENCE.I) driven by the same stimulus.
module tb_rv_decode_stage;

    logic        clk = 1'b0;
    logic        reset_n, flush, in_valid, out_ready, in_is_compressed;
    logic [31:0] in_IR, in_PC;

    logic [4:0]  rs1, rs2, out_rd;
    logic [11:0] csr;
    logic        in_ready, out_valid;
    logic [31:0] out_IR, out_PC;
    logic [3:0]  out_op;
    logic        out_use_rs1, out_use_rs2, out_use_imm, out_save_to_rd;
    logic        out_csr_write, out_illegal, out_is_compressed;

    logic [4:0]  m_rs1, m_rs2, m_out_rd;
    logic [11:0] m_csr;
    logic        m_in_ready, m_out_valid;
    logic [31:0] m_out_IR, m_out_PC;
    logic [3:0]  m_out_op;
    logic        m_use_rs1, m_use_rs2, m_use_imm, m_save_to_rd;
    logic        m_csr_write, m_illegal, m_is_compressed;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rv_decode_stage dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_IR(in_IR), .in_PC(in_PC),
        .in_is_compressed(in_is_compressed),
        .rs1(rs1), .rs2(rs2), .csr(csr),
        .out_valid(out_valid), .out_ready(out_ready), .out_IR(out_IR), .out_PC(out_PC),
        .out_rd(out_rd), .out_op(out_op), .out_use_rs1(out_use_rs1),
        .out_use_rs2(out_use_rs2), .out_use_imm(out_use_imm),
        .out_save_to_rd(out_save_to_rd), .out_csr_write(out_csr_write),
        .out_illegal(out_illegal), .out_is_compressed(out_is_compressed)
    );

    rv_decode_stage #(.ENABLE_M(1'b0), .ENABLE_ZICSR(1'b0), .ENABLE_FENCE_I(1'b0)) dut_min (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(m_in_ready), .in_IR(in_IR), .in_PC(in_PC),
        .in_is_compressed(in_is_compressed),
        .rs1(m_rs1), .rs2(m_rs2), .csr(m_csr),
        .out_valid(m_out_valid), .out_ready(out_ready), .out_IR(m_out_IR), .out_PC(m_out_PC),
        .out_rd(m_out_rd), .out_op(m_out_op), .out_use_rs1(m_use_rs1),
        .out_use_rs2(m_use_rs2), .out_use_imm(m_use_imm),
        .out_save_to_rd(m_save_to_rd), .out_csr_write(m_csr_write),
        .out_illegal(m_illegal), .out_is_compressed(m_is_compressed)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // flags = {use_rs1, use_rs2, use_imm, save_to_rd, csr_write, illegal}
    task automatic apply(input string tag, input logic [31:0] ir, input logic [3:0] op,
                         input logic [5:0] flags, input logic [3:0] op_min);
        in_valid         = 1'b1;
        in_IR            = ir;
        in_PC            = in_PC + 32'd4;
        in_is_compressed = in_PC[2];
        #1;
        check({tag, ".rs1"}, 64'(rs1), 64'(ir[19:15]));
        check({tag, ".csr"}, 64'(csr), 64'(ir[31:20]));
        step();
        check({tag, ".valid"}, 64'(out_valid), 64'd1);
        check({tag, ".op"}, 64'(out_op), 64'(op));
        check({tag, ".flags"}, 64'({out_use_rs1, out_use_rs2, out_use_imm, out_save_to_rd,
                                    out_csr_write, out_illegal}), 64'(flags));
        check({tag, ".ir"}, 64'(out_IR), 64'(ir));
        check({tag, ".rd"}, 64'(out_rd), 64'(ir[11:7]));
        check({tag, ".pc"}, 64'(out_PC), 64'(in_PC));
        check({tag, ".cmp"}, 64'(out_is_compressed), 64'(in_PC[2]));
        check({tag, ".op_min"}, 64'(m_out_op), 64'(op_min));
    endtask

    initial begin
        reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_IR = '0; in_PC = 32'h100; in_is_compressed = 1'b0;
        step(); step();
        check("rst.valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.op", 64'(out_op), 64'd0);
        check("rst.ir", 64'(out_IR), 64'd0);
        reset_n = 1'b1;
        out_ready = 1'b1;

        apply("addi",   32'h00510093, 4'd0,  6'b101100, 4'd0);
        check("addi.rd1", 64'(out_rd), 64'd1);
        check("addi.in_ready", 64'(in_ready), 64'd1);
        apply("mul",    32'h022081B3, 4'd1,  6'b110100, 4'd15);
        apply("add",    32'h002081B3, 4'd0,  6'b110100, 4'd0);
        apply("sub",    32'h402081B3, 4'd0,  6'b110100, 4'd0);
        apply("badf7",  32'h042081B3, 4'd15, 6'b000001, 4'd15);
        apply("csrrs0", 32'h30002073, 4'd9,  6'b100000, 4'd15);
        apply("csrrw",  32'h300110F3, 4'd9,  6'b100110, 4'd15);
        apply("mret",   32'h30200073, 4'd10, 6'b000000, 4'd10);
        apply("wfi",    32'h10500073, 4'd11, 6'b000000, 4'd11);
        apply("ecall",  32'h00000073, 4'd15, 6'b000001, 4'd15);
        apply("sys100", 32'h00004073, 4'd15, 6'b000001, 4'd15);
        apply("zero",   32'h00000000, 4'd15, 6'b000001, 4'd15);
        apply("ones",   32'hFFFFFFFF, 4'd15, 6'b000001, 4'd15);
        apply("rvc",    32'h00000001, 4'd15, 6'b000001, 4'd15);
        apply("fence",  32'h0000000F, 4'd13, 6'b000000, 4'd13);
        apply("fencei", 32'h0000100F, 4'd12, 6'b000000, 4'd13);
        apply("mm010",  32'h0000200F, 4'd15, 6'b000001, 4'd15);
        apply("lui",    32'h123452B7, 4'd2,  6'b000100, 4'd2);
        apply("auipc",  32'h00000297, 4'd3,  6'b000100, 4'd3);
        apply("jal",    32'h000000EF, 4'd4,  6'b000100, 4'd4);
        apply("jalr",   32'h00008067, 4'd5,  6'b100100, 4'd5);
        apply("beq",    32'h00208063, 4'd6,  6'b110000, 4'd6);
        apply("lw",     32'h0000A183, 4'd7,  6'b100100, 4'd7);
        apply("sw",     32'h0020A023, 4'd8,  6'b110000, 4'd8);
        apply("amo",    32'h0000002B, 4'd15, 6'b000001, 4'd15);
        in_valid = 1'b0;
        step();
        check("idle.valid", 64'(out_valid), 64'd0);

        // Back-pressure: A into O, B into S, C refused until S frees
        out_ready = 1'b0;
        in_valid = 1'b1; in_IR = 32'h00100093; step();
        check("bp.a_in_o", 64'(out_IR), 64'h00100093);
        check("bp.rdy1", 64'(in_ready), 64'd1);
        in_IR = 32'h00200113; step();
        check("bp.a_held", 64'(out_IR), 64'h00100093);
        check("bp.rdy2", 64'(in_ready), 64'd0);
        in_IR = 32'h00300193; step();
        check("bp.a_held2", 64'(out_IR), 64'h00100093);
        check("bp.rdy3", 64'(in_ready), 64'd0);
        check("bp.valid3", 64'(out_valid), 64'd1);
        out_ready = 1'b1; step();
        check("bp.b_out", 64'(out_IR), 64'h00200113);
        check("bp.b_rd", 64'(out_rd), 64'd2);
        check("bp.rdy4", 64'(in_ready), 64'd1);
        step();
        check("bp.c_out", 64'(out_IR), 64'h00300193);
        check("bp.c_valid", 64'(out_valid), 64'd1);
        in_valid = 1'b0; step();
        check("bp.empty", 64'(out_valid), 64'd0);

        // Flush with O and S full and a new instruction offered
        out_ready = 1'b0;
        in_valid = 1'b1; in_IR = 32'h00400213; step();
        in_IR = 32'h00500293; step();
        check("fl.full", 64'(in_ready), 64'd0);
        in_IR = 32'h00600313; flush = 1'b1; step();
        check("fl.valid", 64'(out_valid), 64'd0);
        check("fl.rdy", 64'(in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; step();
        check("fl.gone1", 64'(out_valid), 64'd0);
        step();
        check("fl.gone2", 64'(out_valid), 64'd0);
        // Instruction accepted in the flush cycle is dropped
        in_valid = 1'b1; in_IR = 32'h00700393; flush = 1'b1; step();
        check("fl.acc_drop", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; step();
        check("fl.acc_drop2", 64'(out_valid), 64'd0);

        // Reset mid-stream with S full
        out_ready = 1'b0;
        in_valid = 1'b1; in_IR = 32'h00800413; step();
        in_IR = 32'h00900493; step();
        check("rs.full", 64'(in_ready), 64'd0);
        in_valid = 1'b0; reset_n = 1'b0; step();
        check("rs.valid", 64'(out_valid), 64'd0);
        check("rs.rdy", 64'(in_ready), 64'd1);
        check("rs.ir", 64'(out_IR), 64'd0);
        check("rs.pc", 64'(out_PC), 64'd0);
        check("rs.rd", 64'(out_rd), 64'd0);
        check("rs.flags", 64'({out_use_rs1, out_use_imm, out_save_to_rd, out_illegal}), 64'd0);
        reset_n = 1'b1; out_ready = 1'b1; step();
        check("rs.after", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
